// File: rtl/xbus_pkg.sv
// Shared types and constants for the xbus CPU-side write buffer.
package xbus_pkg;

  localparam int AW = 22;
  localparam int DW = 32;

  // Bus engine state, one-hot.
  typedef enum logic [2:0] {
    B_IDLE = 3'b001,
    B_REQ  = 3'b010,
    B_REL  = 3'b100
  } bstate_t;

  // One posted write: word address plus data.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wbuf_entry_t;

  // Address map seen by the bus interface.
  localparam logic [AW-1:0] MAP_DRAM_BASE   = 22'o00000000;
  localparam logic [AW-1:0] MAP_IO_BASE     = 22'o17000000;
  localparam logic [AW-1:0] MAP_UNIBUS_BASE = 22'o17400000;

  // True for addresses that decode to the I/O window.
  function automatic logic is_io(input logic [AW-1:0] a);
    return a >= MAP_IO_BASE;
  endfunction

endpackage

// File: rtl/xbus_wbuf_if.sv
// CPU request port and bus-interface master port bundled together.
interface xbus_wbuf_if #(parameter int PTRW = 2) ();
  import xbus_pkg::*;

  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_req;
  logic          cpu_write;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] addr;
  logic [DW-1:0] busout;
  logic [DW-1:0] busin;
  logic          req;
  logic          write;
  logic          ack;
  logic          load;
  logic [PTRW:0] wbuf_count;
  logic          busy;

  // Write-buffer side.
  modport master (
    input  cpu_addr, cpu_wdata, cpu_req, cpu_write, busin, ack, load,
    output cpu_ack, cpu_rdata, addr, busout, req, write, wbuf_count, busy
  );

  // CPU and bus-interface side.
  modport slave (
    output cpu_addr, cpu_wdata, cpu_req, cpu_write, busin, ack, load,
    input  cpu_ack, cpu_rdata, addr, busout, req, write, wbuf_count, busy
  );

endinterface

// File: rtl/wbuf_fifo.sv
// Small synchronous FIFO with combinational head; push while full is legal
// when a pop happens in the same cycle.
module wbuf_fifo
  import xbus_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          push,
  input  logic          pop,
  input  wbuf_entry_t   din,
  output wbuf_entry_t   head,
  output logic          full,
  output logic          empty,
  output logic [PTRW:0] count
);

  localparam logic [PTRW-1:0] PTR_ONE = {{(PTRW-1){1'b0}}, 1'b1};
  localparam logic [PTRW:0]   CNT_ONE = {{PTRW{1'b0}}, 1'b1};
  localparam logic [PTRW:0]   CNT_MAX = (PTRW+1)'(DEPTH);

  wbuf_entry_t     mem [DEPTH];
  logic [PTRW-1:0] wr_ptr_reg;
  logic [PTRW-1:0] rd_ptr_reg;
  logic [PTRW:0]   count_reg;

  // Entry storage; contents need no reset since count guards them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= din;
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign full  = (count_reg == CNT_MAX);
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/xbus_wbuf.sv
// CPU front end for xbus: posts writes into a FIFO, issues reads only once
// the FIFO has drained, and runs the four-phase req/ack bus handshake.
module xbus_wbuf
  import xbus_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic mclk,
  input  logic reset,
  xbus_wbuf_if.master xb
);

  bstate_t       state_reg;
  logic          req_reg;
  logic          write_reg;
  logic          cpu_ack_reg;
  logic          busy_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] busout_reg;
  logic [DW-1:0] rdata_reg;

  wbuf_entry_t   head;
  wbuf_entry_t   din;
  logic          full;
  logic          empty;
  logic [PTRW:0] count;
  logic          push;
  logic          pop;
  logic          rd_accept;

  // A posted write retires when the bus acks it.
  assign pop = (state_reg == B_REQ) & write_reg & xb.ack;
  // cpu_req is ignored in the cpu_ack cycle so one request is taken once.
  // A retiring entry frees its slot in the same cycle.
  assign push = xb.cpu_req & xb.cpu_write & ~cpu_ack_reg & (~full | pop);
  // Reads wait for an empty FIFO and an idle engine to keep RAW order.
  assign rd_accept = xb.cpu_req & ~xb.cpu_write & ~cpu_ack_reg & empty &
                     (state_reg == B_IDLE);
  assign din = '{addr: xb.cpu_addr, data: xb.cpu_wdata};

  wbuf_fifo #(.DEPTH(DEPTH), .PTRW(PTRW)) u_fifo (
    .clk   (mclk),
    .srst  (reset),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Bus engine with registered bus outputs, cpu_ack and busy.
  always_ff @(posedge mclk) begin
    if (reset) begin
      state_reg   <= B_IDLE;
      req_reg     <= 1'b0;
      write_reg   <= 1'b0;
      addr_reg    <= '0;
      busout_reg  <= '0;
      rdata_reg   <= '0;
      cpu_ack_reg <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      cpu_ack_reg <= push | ((state_reg == B_REQ) & xb.ack & ~write_reg);
      unique case (state_reg)
        B_IDLE: begin
          if (!empty) begin
            addr_reg   <= head.addr;
            busout_reg <= head.data;
            write_reg  <= 1'b1;
            req_reg    <= 1'b1;
            busy_reg   <= 1'b1;
            state_reg  <= B_REQ;
          end else if (rd_accept) begin
            addr_reg  <= xb.cpu_addr;
            write_reg <= 1'b0;
            req_reg   <= 1'b1;
            busy_reg  <= 1'b1;
            state_reg <= B_REQ;
          end else begin
            busy_reg <= push;
          end
        end
        B_REQ: begin
          busy_reg <= 1'b1;
          if (xb.ack) begin
            req_reg <= 1'b0;
            if (!write_reg && xb.load) rdata_reg <= xb.busin;
            state_reg <= B_REL;
          end
        end
        B_REL: begin
          if (!xb.ack) begin
            state_reg <= B_IDLE;
            busy_reg  <= ~empty | push;
          end else begin
            busy_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= B_IDLE;
          req_reg   <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign xb.addr       = addr_reg;
  assign xb.busout     = busout_reg;
  assign xb.req        = req_reg;
  assign xb.write      = write_reg;
  assign xb.cpu_ack    = cpu_ack_reg;
  assign xb.cpu_rdata  = rdata_reg;
  assign xb.wbuf_count = count;
  assign xb.busy       = busy_reg;

endmodule

// File: doc/xbus_wbuf.md
Name: xbus_wbuf

Overview:
- CPU-side front end for the xbus interface. Sits between the CPU memory request logic (VMA/MD) and the bus interface master port.
- Posts CPU writes into a small FIFO so the CPU can continue without waiting for the bus.
- Reads are issued only after the FIFO has drained. This keeps read-after-write order strict.
- Drives the bus interface's four-phase req/ack handshake and captures read data when load is asserted.

Parameters:
- DEPTH, 4, number of posted-write entries; power of two, range 2..16.
- PTRW, 2, pointer width; equals log2(DEPTH).

Ports:
- mclk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_addr  in  22  CPU word address
- cpu_wdata  in  32  CPU write data
- cpu_req  in  1  CPU request; held high until cpu_ack
- cpu_write  in  1  1 = write, 0 = read; valid while cpu_req is high
- cpu_ack  out  1  one-cycle pulse; request accepted (write) or completed (read)
- cpu_rdata  out  32  read data; valid in the cpu_ack cycle of a read, held afterwards
- addr  out  22  bus interface address
- busout  out  32  write data to the bus interface
- busin  in  32  read data from the bus interface
- req  out  1  bus request
- write  out  1  bus write qualifier
- ack  in  1  bus interface ack; stays high until req drops
- load  in  1  bus interface read-data strobe; coincides with ack on reads
- wbuf_count  out  PTRW+1  number of occupied FIFO entries
- busy  out  1  FIFO not empty, or bus engine not in B_IDLE

Behaviour:
- Reset values:
  - FIFO pointers and count are 0.
  - req, write, cpu_ack and busy are 0.
  - addr, busout and cpu_rdata are 0.
  - Engine state is B_IDLE.
  - A reset during a transaction drops req in the next cycle and discards all posted writes. No cpu_ack is produced.
- FIFO: DEPTH entries of {addr[21:0], data[31:0]}.
  - Pointers wrap modulo DEPTH.
  - Count runs 0..DEPTH. Full when count == DEPTH; empty when count == 0.
- CPU write acceptance:
  - A write is accepted when cpu_req & cpu_write & ~full.
  - The entry is enqueued at the clock edge; cpu_ack pulses in the following cycle.
  - When full, the request is held off (no ack) until an entry retires.
  - Enqueue and dequeue in the same cycle leave the count unchanged. This includes the full case: a retiring entry frees space in that same cycle, so a write presented while full is accepted in the cycle the dequeue occurs.
- CPU read acceptance:
  - A read is accepted only when the FIFO is empty and the engine is in B_IDLE.
  - The engine then issues the read; no prefetch or forwarding.
  - After an accepted request, cpu_req is ignored for one cycle, until cpu_ack has pulsed. This prevents double acceptance.
- Engine states:
  - B_IDLE:
    - FIFO non-empty: load the head entry into addr/busout, write=1, req=1, go to B_REQ.
    - Otherwise, read accepted: load addr, write=0, req=1, go to B_REQ.
    - Writes have priority, but a read is only possible when the FIFO is empty.
  - B_REQ: hold req and all outputs stable until ack=1.
    - Read: ack and load arrive in the same cycle. Capture busin into cpu_rdata on load.
    - Write: ack arrives at least one cycle after the device accepts; dequeue the FIFO head on ack.
    - Then req=0, go to B_REL.
  - B_REL: req=0; wait for ack=0 (bus interface back in idle).
    - Read: cpu_ack pulses in the B_REL entry cycle.
    - Go to B_IDLE when ack=0. req never reasserts in a cycle where ack is 1.
- Bus timeout returns data 0 with ack; the block treats it as a normal completion. There is no separate error path.
- Latency:
  - Write: cpu_ack 1 cycle after cpu_req is sampled (FIFO not full).
  - Read from idle: req rises 1 cycle after acceptance. cpu_ack is 1 cycle after the load cycle.
- wbuf_count and busy are registered and reflect the state after each edge.

Decomposition:
- Shared package xbus_pkg holds:
  - engine state encoding B_IDLE/B_REQ/B_REL (one-hot, 3 bits)
  - address width 22, data width 32
  - address map constants used by the bus interface
- One sub-module: wbuf_fifo.
  - Parameterised synchronous FIFO: push/pop/full/empty/count, head output.
  - Simultaneous push/pop is allowed, including push while full with pop asserted.

Test Plan:
- Single write: addr 0o1000, data 32'h12345678, bus model acks after 3 cycles.
  - cpu_ack at cycle+1; req high until ack; one bus write with exact addr/data; wbuf_count 1->0.
- Burst of 6 writes (DEPTH=4) with slow ack (8 cycles).
  - First 4 acked back-to-back; 5th stalls until the first retire; bus order identical to CPU order; count never exceeds 4.
- Write 0o2000 <- 32'hDEADBEEF then immediate read 0o2000.
  - Read req only after the write's ack has fallen; cpu_rdata 32'hDEADBEEF from the model; exactly one cpu_ack for the read.
- Read where the model returns ack+load with busin 32'hCAFEF00D.
  - cpu_rdata = 32'hCAFEF00D in the cpu_ack cycle; req drops the cycle after load; no new req while ack=1.
- Timeout read: the model asserts ack+load with busin 0 after 63 cycles.
  - cpu_rdata 0; engine returns to B_IDLE; busy falls.
- Reset asserted in B_REQ with 3 posted writes.
  - Next cycle: req=0, wbuf_count=0, busy=0, no cpu_ack; a subsequent write works normally.
